// File: rtl/ulpi_phy_cmd.sv
// ULPI link-side command engine: issues PHY register writes and NOPID transmits,
// backs off and re-issues when the PHY takes the bus (dir) mid-command.
module ulpi_phy_cmd (
    input  logic       clock,
    input  logic       reset,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_stp_o,
    input  logic       phy_write_i,
    input  logic       phy_nopid_i,
    input  logic       phy_stop_i,
    input  logic [7:0] phy_addr_i,
    input  logic [7:0] phy_data_i,
    output logic       phy_busy_o,
    output logic       phy_done_o
);

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] BUS_IDLE  = 8'h00;
    localparam logic [DATA_W-1:0] NOPID_CMD = 8'h40;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        REG_CMD,
        REG_DATA,
        REG_STOP,
        NOP_CMD,
        NOP_DATA,
        NOP_STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              nop_q;   // latched command kind, used for re-issue after TURN
    logic              turn_q;  // dir seen low once; next low cycle ends turnaround

    // Command sequencer with registered bus and handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            nop_q       <= 1'b0;
            turn_q      <= 1'b0;
            ulpi_data_o <= BUS_IDLE;
            ulpi_stp_o  <= 1'b0;
            phy_busy_o  <= 1'b0;
            phy_done_o  <= 1'b0;
        end else begin
            ulpi_stp_o <= 1'b0;
            phy_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    ulpi_data_o <= BUS_IDLE;
                    // done high means the requester has not yet seen completion
                    if (!ulpi_dir_i && !phy_done_o) begin
                        if (phy_write_i) begin
                            addr_q      <= phy_addr_i;
                            data_q      <= phy_data_i;
                            nop_q       <= 1'b0;
                            phy_busy_o  <= 1'b1;
                            ulpi_data_o <= phy_addr_i;
                            state       <= REG_CMD;
                        end else if (phy_nopid_i) begin
                            nop_q       <= 1'b1;
                            phy_busy_o  <= 1'b1;
                            ulpi_data_o <= NOPID_CMD;
                            state       <= NOP_CMD;
                        end
                    end
                end
                TURN: begin
                    ulpi_data_o <= BUS_IDLE;
                    if (ulpi_dir_i) begin
                        turn_q <= 1'b0;
                    end else if (!turn_q) begin
                        turn_q <= 1'b1;
                    end else begin
                        turn_q <= 1'b0;
                        if (nop_q) begin
                            ulpi_data_o <= NOPID_CMD;
                            state       <= NOP_CMD;
                        end else begin
                            ulpi_data_o <= addr_q;
                            state       <= REG_CMD;
                        end
                    end
                end
                REG_CMD: begin
                    if (ulpi_dir_i) begin
                        ulpi_data_o <= BUS_IDLE;
                        turn_q      <= 1'b0;
                        state       <= TURN;
                    end else if (ulpi_nxt_i) begin
                        ulpi_data_o <= data_q;
                        state       <= REG_DATA;
                    end
                end
                REG_DATA: begin
                    if (ulpi_dir_i) begin
                        ulpi_data_o <= BUS_IDLE;
                        turn_q      <= 1'b0;
                        state       <= TURN;
                    end else if (ulpi_nxt_i) begin
                        ulpi_data_o <= BUS_IDLE;
                        ulpi_stp_o  <= 1'b1;
                        state       <= REG_STOP;
                    end
                end
                NOP_CMD: begin
                    if (ulpi_dir_i) begin
                        ulpi_data_o <= BUS_IDLE;
                        turn_q      <= 1'b0;
                        state       <= TURN;
                    end else if (ulpi_nxt_i) begin
                        ulpi_data_o <= BUS_IDLE;
                        state       <= NOP_DATA;
                    end
                end
                NOP_DATA: begin
                    ulpi_data_o <= BUS_IDLE;
                    if (ulpi_dir_i) begin
                        turn_q <= 1'b0;
                        state  <= TURN;
                    end else if (phy_stop_i) begin
                        ulpi_stp_o <= 1'b1;
                        state      <= NOP_STOP;
                    end
                end
                REG_STOP, NOP_STOP: begin
                    // dir is ignored here: the stp has already been issued
                    ulpi_data_o <= BUS_IDLE;
                    phy_busy_o  <= 1'b0;
                    phy_done_o  <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    ulpi_data_o <= BUS_IDLE;
                    phy_busy_o  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_phy_cmd.sv
// Bench for ulpi_phy_cmd: cycle-scheduled scenarios with a scoreboard of bytes
// the PHY accepts (nxt high while the link drives a command byte).
module tb_ulpi_phy_cmd;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ulpi_dir_i = 1'b0;
    logic       ulpi_nxt_i = 1'b0;
    logic [7:0] ulpi_data_o;
    logic       ulpi_stp_o;
    logic       phy_write_i = 1'b0;
    logic       phy_nopid_i = 1'b0;
    logic       phy_stop_i = 1'b0;
    logic [7:0] phy_addr_i = 8'h00;
    logic [7:0] phy_data_i = 8'h00;
    logic       phy_busy_o;
    logic       phy_done_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] xfer_q[$];
    logic [7:0] exp_b;
    logic [10:0] obs;

    assign obs = {ulpi_data_o, ulpi_stp_o, phy_busy_o, phy_done_o};

    ulpi_phy_cmd dut (
        .clock       (clock),
        .reset       (reset),
        .ulpi_dir_i  (ulpi_dir_i),
        .ulpi_nxt_i  (ulpi_nxt_i),
        .ulpi_data_o (ulpi_data_o),
        .ulpi_stp_o  (ulpi_stp_o),
        .phy_write_i (phy_write_i),
        .phy_nopid_i (phy_nopid_i),
        .phy_stop_i  (phy_stop_i),
        .phy_addr_i  (phy_addr_i),
        .phy_data_i  (phy_data_i),
        .phy_busy_o  (phy_busy_o),
        .phy_done_o  (phy_done_o)
    );

    always #5 clock = ~clock;

    // PHY-side view: a byte is taken when nxt is high while the link drives a command
    always @(negedge clock) begin
        if (!reset && ulpi_nxt_i && !ulpi_dir_i && phy_busy_o && !ulpi_stp_o) begin
            checks++;
            if (xfer_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got %h want none", ulpi_data_o);
            end else begin
                exp_b = xfer_q.pop_front();
                if (ulpi_data_o !== exp_b) begin
                    errors++;
                    $display("FAIL xfer_byte: got %h want %h", ulpi_data_o, exp_b);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL reset_state: got %h want %h", obs, {8'h00, 3'b000}); end
        reset = 1'b0;
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, {8'h00, 3'b000}); end
    endtask

    task automatic test_reg_write;
        xfer_q.push_back(8'h8A); xfer_q.push_back(8'h00);
        phy_write_i = 1'b1; phy_addr_i = 8'h8A; phy_data_i = 8'h00;
        tick();
        checks++; if (obs !== {8'h8A, 3'b010}) begin errors++; $display("FAIL wr_cmd: got %h want %h", obs, {8'h8A, 3'b010}); end
        tick();
        checks++; if (obs !== {8'h8A, 3'b010}) begin errors++; $display("FAIL wr_cmd_wait: got %h want %h", obs, {8'h8A, 3'b010}); end
        ulpi_nxt_i = 1'b1;
        tick(); ulpi_nxt_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b010}) begin errors++; $display("FAIL wr_data: got %h want %h", obs, {8'h00, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b1;
        checks++; if (obs !== {8'h00, 3'b010}) begin errors++; $display("FAIL wr_data_wait: got %h want %h", obs, {8'h00, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b110}) begin errors++; $display("FAIL wr_stp: got %h want %h", obs, {8'h00, 3'b110}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b001}) begin errors++; $display("FAIL wr_done: got %h want %h", obs, {8'h00, 3'b001}); end
        phy_write_i = 1'b0;
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL wr_idle: got %h want %h", obs, {8'h00, 3'b000}); end
    endtask

    task automatic test_abort;
        xfer_q.push_back(8'h84); xfer_q.push_back(8'h84); xfer_q.push_back(8'h45);
        phy_write_i = 1'b1; phy_addr_i = 8'h84; phy_data_i = 8'h45;
        tick(); ulpi_nxt_i = 1'b1;
        checks++; if (obs !== {8'h84, 3'b010}) begin errors++; $display("FAIL ab_cmd: got %h want %h", obs, {8'h84, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b0; ulpi_dir_i = 1'b1;
        checks++; if (obs !== {8'h45, 3'b010}) begin errors++; $display("FAIL ab_data: got %h want %h", obs, {8'h45, 3'b010}); end
        tick(); phy_addr_i = 8'hFF; phy_data_i = 8'hFF;
        checks++; if (obs !== {8'h00, 3'b010}) begin errors++; $display("FAIL ab_turn0: got %h want %h", obs, {8'h00, 3'b010}); end
        tick(); ulpi_dir_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b010}) begin errors++; $display("FAIL ab_turn1: got %h want %h", obs, {8'h00, 3'b010}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b010}) begin errors++; $display("FAIL ab_turnaround: got %h want %h", obs, {8'h00, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b1;
        checks++; if (obs !== {8'h84, 3'b010}) begin errors++; $display("FAIL ab_reissue_cmd: got %h want %h", obs, {8'h84, 3'b010}); end
        tick();
        checks++; if (obs !== {8'h45, 3'b010}) begin errors++; $display("FAIL ab_reissue_data: got %h want %h", obs, {8'h45, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b110}) begin errors++; $display("FAIL ab_stp: got %h want %h", obs, {8'h00, 3'b110}); end
        tick(); phy_write_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b001}) begin errors++; $display("FAIL ab_done: got %h want %h", obs, {8'h00, 3'b001}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL ab_single_done: got %h want %h", obs, {8'h00, 3'b000}); end
    endtask

    task automatic test_nopid;
        int bad = 0;
        xfer_q.push_back(8'h40);
        phy_nopid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (obs !== {8'h40, 3'b010}) begin errors++; $display("FAIL nop_cmd[%0d]: got %h want %h", i, obs, {8'h40, 3'b010}); end
            phy_stop_i = (i == 0);
            ulpi_nxt_i = (i == 2);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            ulpi_nxt_i = 1'b0;
            if (obs !== {8'h00, 3'b010}) bad++;
            phy_stop_i = (i == 99);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nop_data_hold: got %0d bad cycles want 0", bad); end
        tick(); phy_stop_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b110}) begin errors++; $display("FAIL nop_stp: got %h want %h", obs, {8'h00, 3'b110}); end
        tick(); phy_nopid_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b001}) begin errors++; $display("FAIL nop_done: got %h want %h", obs, {8'h00, 3'b001}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL nop_idle: got %h want %h", obs, {8'h00, 3'b000}); end
    endtask

    task automatic test_priority_and_reset;
        xfer_q.push_back(8'h8A); xfer_q.push_back(8'h5C); xfer_q.push_back(8'h40);
        phy_write_i = 1'b1; phy_nopid_i = 1'b1; phy_addr_i = 8'h8A; phy_data_i = 8'h5C;
        tick(); ulpi_nxt_i = 1'b1;
        checks++; if (obs !== {8'h8A, 3'b010}) begin errors++; $display("FAIL pri_write_first: got %h want %h", obs, {8'h8A, 3'b010}); end
        tick();
        checks++; if (obs !== {8'h5C, 3'b010}) begin errors++; $display("FAIL pri_data: got %h want %h", obs, {8'h5C, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b110}) begin errors++; $display("FAIL pri_stp: got %h want %h", obs, {8'h00, 3'b110}); end
        tick(); phy_write_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b001}) begin errors++; $display("FAIL pri_done: got %h want %h", obs, {8'h00, 3'b001}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL pri_gap: got %h want %h", obs, {8'h00, 3'b000}); end
        tick(); ulpi_nxt_i = 1'b1;
        checks++; if (obs !== {8'h40, 3'b010}) begin errors++; $display("FAIL pri_nop_cmd: got %h want %h", obs, {8'h40, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b010}) begin errors++; $display("FAIL pri_nop_data: got %h want %h", obs, {8'h00, 3'b010}); end
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; phy_nopid_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL rst_mid_cmd: got %h want %h", obs, {8'h00, 3'b000}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL rst_no_done: got %h want %h", obs, {8'h00, 3'b000}); end
    endtask

    task automatic test_dir_idle;
        xfer_q.push_back(8'h84); xfer_q.push_back(8'h12);
        ulpi_dir_i = 1'b1; phy_write_i = 1'b1; phy_addr_i = 8'h84; phy_data_i = 8'h12;
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL dir_block0: got %h want %h", obs, {8'h00, 3'b000}); end
        tick(); ulpi_dir_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL dir_block1: got %h want %h", obs, {8'h00, 3'b000}); end
        tick(); ulpi_nxt_i = 1'b1;
        checks++; if (obs !== {8'h84, 3'b010}) begin errors++; $display("FAIL dir_release_cmd: got %h want %h", obs, {8'h84, 3'b010}); end
        tick();
        checks++; if (obs !== {8'h12, 3'b010}) begin errors++; $display("FAIL dir_data: got %h want %h", obs, {8'h12, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b0; ulpi_dir_i = 1'b1;
        checks++; if (obs !== {8'h00, 3'b110}) begin errors++; $display("FAIL dir_stp: got %h want %h", obs, {8'h00, 3'b110}); end
        tick(); ulpi_dir_i = 1'b0; phy_write_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b001}) begin errors++; $display("FAIL dir_stop_no_abort: got %h want %h", obs, {8'h00, 3'b001}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL dir_idle: got %h want %h", obs, {8'h00, 3'b000}); end
    endtask

    task automatic test_back_to_back;
        xfer_q.push_back(8'hA1); xfer_q.push_back(8'hB2);
        xfer_q.push_back(8'hC3); xfer_q.push_back(8'hD4);
        phy_write_i = 1'b1; phy_addr_i = 8'hA1; phy_data_i = 8'hB2; ulpi_nxt_i = 1'b1;
        tick();
        checks++; if (obs !== {8'hA1, 3'b010}) begin errors++; $display("FAIL b2b_cmd0: got %h want %h", obs, {8'hA1, 3'b010}); end
        tick();
        checks++; if (obs !== {8'hB2, 3'b010}) begin errors++; $display("FAIL b2b_data0: got %h want %h", obs, {8'hB2, 3'b010}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b110}) begin errors++; $display("FAIL b2b_stp0: got %h want %h", obs, {8'h00, 3'b110}); end
        tick(); phy_addr_i = 8'hC3; phy_data_i = 8'hD4;
        checks++; if (obs !== {8'h00, 3'b001}) begin errors++; $display("FAIL b2b_done0: got %h want %h", obs, {8'h00, 3'b001}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL b2b_gap: got %h want %h", obs, {8'h00, 3'b000}); end
        tick();
        checks++; if (obs !== {8'hC3, 3'b010}) begin errors++; $display("FAIL b2b_cmd1: got %h want %h", obs, {8'hC3, 3'b010}); end
        tick();
        checks++; if (obs !== {8'hD4, 3'b010}) begin errors++; $display("FAIL b2b_data1: got %h want %h", obs, {8'hD4, 3'b010}); end
        tick(); ulpi_nxt_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b110}) begin errors++; $display("FAIL b2b_stp1: got %h want %h", obs, {8'h00, 3'b110}); end
        tick(); phy_write_i = 1'b0;
        checks++; if (obs !== {8'h00, 3'b001}) begin errors++; $display("FAIL b2b_done1: got %h want %h", obs, {8'h00, 3'b001}); end
        tick();
        checks++; if (obs !== {8'h00, 3'b000}) begin errors++; $display("FAIL b2b_idle: got %h want %h", obs, {8'h00, 3'b000}); end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_abort();
        test_nopid();
        test_priority_and_reset();
        test_dir_idle();
        test_back_to_back();
        tick();
        checks++;
        if (xfer_q.size() != 0) begin
            errors++;
            $display("FAIL xfer_pending: got %0d bytes left want 0", xfer_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
